// File: rtl/matrix_pkg.sv
// Shared types for the LED-matrix tile sampler: default grid size, pixel and
// sample records, and the sampler FSM encoding.
package matrix_pkg;

  localparam int COLS_DEF = 16;
  localparam int ROWS_DEF = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [$clog2(COLS_DEF)-1:0] x;
    logic [$clog2(ROWS_DEF)-1:0] y;
    rgb888_t                     rgb;
  } tile_sample_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/matrix_tile_sampler_if.sv
// Pixel stream / geometry in, tile samples out. The master side is the
// upstream sync manager plus the downstream consumer; the slave is the sampler.
interface matrix_tile_sampler_if #(
  parameter int COLS = 16,
  parameter int ROWS = 8,
  parameter int WB   = 11,
  parameter int HB   = 11
);
  logic                    I_rgb_de;
  logic [7:0]              I_rgb_r;
  logic [7:0]              I_rgb_g;
  logic [7:0]              I_rgb_b;
  logic [WB-1:0]           I_image_width;
  logic [HB-1:0]           I_image_height;
  logic                    I_width_valid;
  logic                    I_height_valid;
  logic                    I_new_row;
  logic                    I_new_frame;
  logic                    O_sample_valid;
  logic [$clog2(COLS)-1:0] O_sample_x;
  logic [$clog2(ROWS)-1:0] O_sample_y;
  logic [23:0]             O_sample_rgb;
  logic                    O_frame_done;
  logic                    O_geom_error;

  modport master (
    output I_rgb_de, I_rgb_r, I_rgb_g, I_rgb_b, I_image_width, I_image_height,
           I_width_valid, I_height_valid, I_new_row, I_new_frame,
    input  O_sample_valid, O_sample_x, O_sample_y, O_sample_rgb, O_frame_done,
           O_geom_error
  );

  modport slave (
    input  I_rgb_de, I_rgb_r, I_rgb_g, I_rgb_b, I_image_width, I_image_height,
           I_width_valid, I_height_valid, I_new_row, I_new_frame,
    output O_sample_valid, O_sample_x, O_sample_y, O_sample_rgb, O_frame_done,
           O_geom_error
  );
endinterface

// File: rtl/bresenham_stepper.sv
// Division-free decimator: fires `hit` on roughly one advance in total/STEP,
// starting half a period in so each hit lands mid-tile.
module bresenham_stepper #(
  parameter int STEP  = 16,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [ACC_W-1:0] total,
  input  logic             advance,
  output logic             hit
);
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W-1:0] sum_s;

  // An init in the same cycle as an advance steps from the fresh offset.
  always_comb begin
    base_s = init ? (total >> 1) : acc_r;
    sum_s  = base_s + ACC_W'(STEP);
    hit    = advance && (sum_s >= total);
  end

  // Accumulator update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (hit) begin
      acc_r <= sum_s - total;
    end else if (advance) begin
      acc_r <= sum_s;
    end else if (init) begin
      acc_r <= base_s;
    end
  end
endmodule

// File: rtl/matrix_tile_sampler.sv
// Picks one centred pixel per LED tile from the DVI stream and emits it with
// its tile coordinates, one cycle after the pixel was seen.
module matrix_tile_sampler
  import matrix_pkg::*;
#(
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080
) (
  input logic                  I_rgb_clk,
  input logic                  I_rst,
  matrix_tile_sampler_if.slave bus
);
  localparam int WB = $clog2(MAX_WIDTH);
  localparam int HB = $clog2(MAX_HEIGHT);
  localparam int AW = ((WB > HB) ? WB : HB) + 1;
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  sampler_state_t state_r;
  logic [WB-1:0]  wl_r;
  logic [HB-1:0]  hl_r;
  logic           de_d_r;
  logic           sel_line_r;
  logic [YW-1:0]  cur_y_r;
  logic [YW:0]    rows_taken_r;
  logic [XW:0]    cols_taken_r;
  logic           done_pend_r;
  logic           valid_r;
  logic [XW-1:0]  x_r;
  logic [YW-1:0]  y_r;
  rgb888_t        rgb_r;
  logic           frame_done_r;
  logic           geom_err_r;

  logic           geom_ok_s, too_small_s, live_s, de_rise_s, line_start_s;
  logic           line_sel_s, h_init_s, h_adv_s, take_s, last_s;
  logic           v_hit_s, h_hit_s;
  logic [YW-1:0]  line_y_s;
  logic [XW:0]    x_cnt_s;
  logic [AW-1:0]  v_total_s, h_total_s;

  // Line/pixel selection; a line start decides its own first pixel in-cycle.
  always_comb begin
    geom_ok_s    = bus.I_width_valid && bus.I_height_valid;
    too_small_s  = (bus.I_image_width < WB'(COLS)) || (bus.I_image_height < HB'(ROWS));
    live_s       = ((state_r == S_ARMED) || (state_r == S_ACTIVE)) && !bus.I_new_frame;
    de_rise_s    = bus.I_rgb_de && !de_d_r;
    line_start_s = live_s && de_rise_s;
    v_total_s    = bus.I_new_frame ? AW'(bus.I_image_height) : AW'(hl_r);
    h_total_s    = bus.I_new_frame ? AW'(bus.I_image_width) : AW'(wl_r);
    line_sel_s   = line_start_s ? (v_hit_s && (rows_taken_r < (YW+1)'(ROWS))) : sel_line_r;
    line_y_s     = line_start_s ? rows_taken_r[YW-1:0] : cur_y_r;
    h_init_s     = bus.I_new_row || de_rise_s || bus.I_new_frame;
    x_cnt_s      = h_init_s ? '0 : cols_taken_r;
    h_adv_s      = live_s && bus.I_rgb_de && line_sel_s;
    take_s       = h_hit_s && (x_cnt_s < (XW+1)'(COLS));
    last_s       = take_s && (x_cnt_s == (XW+1)'(COLS - 1)) && (line_y_s == YW'(ROWS - 1));
  end

  bresenham_stepper #(.STEP(ROWS), .ACC_W(AW)) u_v_step (
    .clk(I_rgb_clk), .rst(I_rst), .init(bus.I_new_frame), .total(v_total_s),
    .advance(line_start_s), .hit(v_hit_s)
  );

  bresenham_stepper #(.STEP(COLS), .ACC_W(AW)) u_h_step (
    .clk(I_rgb_clk), .rst(I_rst), .init(h_init_s), .total(h_total_s),
    .advance(h_adv_s), .hit(h_hit_s)
  );

  // Frame FSM, tile indices and registered sample outputs.
  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      state_r      <= S_IDLE;
      wl_r         <= '0;
      hl_r         <= '0;
      de_d_r       <= 1'b0;
      sel_line_r   <= 1'b0;
      cur_y_r      <= '0;
      rows_taken_r <= '0;
      cols_taken_r <= '0;
      done_pend_r  <= 1'b0;
      valid_r      <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      rgb_r        <= '0;
      frame_done_r <= 1'b0;
      geom_err_r   <= 1'b0;
    end else begin
      de_d_r       <= bus.I_rgb_de;
      valid_r      <= 1'b0;
      frame_done_r <= done_pend_r;
      done_pend_r  <= 1'b0;
      if (bus.I_new_frame) begin
        geom_err_r   <= geom_ok_s && too_small_s;
        sel_line_r   <= 1'b0;
        cur_y_r      <= '0;
        rows_taken_r <= '0;
        cols_taken_r <= '0;
        if (geom_ok_s && !too_small_s) begin
          wl_r    <= bus.I_image_width;
          hl_r    <= bus.I_image_height;
          state_r <= S_ARMED;
        end else begin
          state_r <= S_IDLE;
        end
      end else begin
        if (h_init_s) begin
          cols_taken_r <= '0;
        end
        if (line_start_s) begin
          state_r    <= S_ACTIVE;
          sel_line_r <= line_sel_s;
          if (line_sel_s) begin
            cur_y_r      <= line_y_s;
            rows_taken_r <= rows_taken_r + (YW+1)'(1);
          end
        end
        if (take_s) begin
          valid_r      <= 1'b1;
          x_r          <= x_cnt_s[XW-1:0];
          y_r          <= line_y_s;
          rgb_r        <= '{r: bus.I_rgb_r, g: bus.I_rgb_g, b: bus.I_rgb_b};
          cols_taken_r <= x_cnt_s + (XW+1)'(1);
        end
        if (last_s) begin
          state_r     <= S_DONE;
          done_pend_r <= 1'b1;
        end
      end
    end
  end

  assign bus.O_sample_valid = valid_r;
  assign bus.O_sample_x     = x_r;
  assign bus.O_sample_y     = y_r;
  assign bus.O_sample_rgb   = rgb_r;
  assign bus.O_frame_done   = frame_done_r;
  assign bus.O_geom_error   = geom_err_r;
endmodule

// File: tb/tb_matrix_tile_sampler.sv
// Directed bench: a 4x2 sampler for the small-geometry scenarios and a default
// 16x8 sampler for full 1920x1080 geometry, both fed from one pixel stream.
module tb_matrix_tile_sampler;
  import matrix_pkg::*;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    int          cyc;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de = 1'b0;
  logic [23:0] pix = 24'd0;
  logic [10:0] width = 11'd0;
  logic [10:0] height = 11'd0;
  logic        wv = 1'b0;
  logic        hv = 1'b0;
  logic        nrow = 1'b0;
  logic        nfrm = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  smp_t q_s[$];
  smp_t q_b[$];
  int done_s = 0;
  int done_b = 0;
  int done_cyc_s = 0;

  always #5 clk = ~clk;

  matrix_tile_sampler_if #(.COLS(4), .ROWS(2), .WB(11), .HB(11)) bus_s ();
  matrix_tile_sampler_if #(.COLS(16), .ROWS(8), .WB(11), .HB(11)) bus_b ();

  assign bus_s.I_rgb_de = de;         assign bus_b.I_rgb_de = de;
  assign bus_s.I_rgb_r = pix[23:16];  assign bus_b.I_rgb_r = pix[23:16];
  assign bus_s.I_rgb_g = pix[15:8];   assign bus_b.I_rgb_g = pix[15:8];
  assign bus_s.I_rgb_b = pix[7:0];    assign bus_b.I_rgb_b = pix[7:0];
  assign bus_s.I_image_width = width; assign bus_b.I_image_width = width;
  assign bus_s.I_image_height = height; assign bus_b.I_image_height = height;
  assign bus_s.I_width_valid = wv;    assign bus_b.I_width_valid = wv;
  assign bus_s.I_height_valid = hv;   assign bus_b.I_height_valid = hv;
  assign bus_s.I_new_row = nrow;      assign bus_b.I_new_row = nrow;
  assign bus_s.I_new_frame = nfrm;    assign bus_b.I_new_frame = nfrm;

  matrix_tile_sampler #(.COLS(4), .ROWS(2), .MAX_WIDTH(1920), .MAX_HEIGHT(1080)) u_small (
    .I_rgb_clk(clk), .I_rst(rst), .bus(bus_s)
  );
  matrix_tile_sampler u_big (
    .I_rgb_clk(clk), .I_rst(rst), .bus(bus_b)
  );

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (bus_s.O_sample_valid === 1'b1)
      q_s.push_back('{int'(bus_s.O_sample_x), int'(bus_s.O_sample_y), bus_s.O_sample_rgb, cyc});
    if (bus_b.O_sample_valid === 1'b1)
      q_b.push_back('{int'(bus_b.O_sample_x), int'(bus_b.O_sample_y), bus_b.O_sample_rgb, cyc});
    if (bus_s.O_frame_done === 1'b1) begin
      done_s = done_s + 1;
      done_cyc_s = cyc;
    end
    if (bus_b.O_frame_done === 1'b1) done_b = done_b + 1;
  end

  task automatic clear_obs();
    q_s.delete();
    q_b.delete();
    done_s = 0;
    done_b = 0;
  endtask

  task automatic start_frame(input int w, input int h);
    @(negedge clk);
    width = 11'(w);
    height = 11'(h);
    wv = 1'b1;
    hv = 1'b1;
    nfrm = 1'b1;
    @(negedge clk);
    nfrm = 1'b0;
  endtask

  task automatic send_line(input int line, input int npix);
    logic [11:0] pc;
    logic [11:0] lc;
    lc = 12'(line);
    @(negedge clk);
    nrow = 1'b1;
    @(negedge clk);
    nrow = 1'b0;
    for (int p = 0; p < npix; p++) begin
      @(negedge clk);
      pc = 12'(p);
      de = 1'b1;
      pix = {pc, lc};
    end
    @(negedge clk);
    de = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int npix);
    for (int l = 0; l < nlines; l++) send_line(l, npix);
    repeat (4) @(negedge clk);
  endtask

  // Sample k of a 4x2 grid over an 8x4 image sits at pixel 2x of line 2y.
  task automatic check_small_grid(input string tag, input int first, input int count);
    logic [23:0] exp;
    for (int k = 0; k < count; k++) begin
      if (first + k < q_s.size()) begin
        exp = {12'(2 * ((first + k) % 4)), 12'(2 * ((first + k) / 4))};
        total++;
        if (q_s[k].x !== (first + k) % 4 || q_s[k].y !== (first + k) / 4 || q_s[k].rgb !== exp) begin
          bad++;
          $display("FAIL %s_sample%0d got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h", tag, k,
                   q_s[k].x, q_s[k].y, q_s[k].rgb, (first + k) % 4, (first + k) / 4, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus_s.O_sample_valid, bus_s.O_sample_x, bus_s.O_sample_y, bus_s.O_sample_rgb,
         bus_s.O_frame_done, bus_s.O_geom_error} !== 30'd0) begin
      bad++;
      $display("FAIL reset_small_outputs got nonzero want 0");
    end
    total++;
    if ({bus_b.O_sample_valid, bus_b.O_sample_x, bus_b.O_sample_y, bus_b.O_sample_rgb,
         bus_b.O_frame_done, bus_b.O_geom_error} !== 34'd0) begin
      bad++;
      $display("FAIL reset_big_outputs got nonzero want 0");
    end
    total++;
    if (u_small.state_r !== S_IDLE) begin
      bad++;
      $display("FAIL reset_state got %0d want %0d", u_small.state_r, S_IDLE);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_grid();
    clear_obs();
    start_frame(8, 4);
    send_frame(4, 8);
    total++;
    if (q_s.size() !== 8) begin
      bad++;
      $display("FAIL basic_count got %0d want 8", q_s.size());
    end
    check_small_grid("basic", 0, 8);
    total++;
    if (done_s !== 1) begin
      bad++;
      $display("FAIL basic_done_count got %0d want 1", done_s);
    end
    if (q_s.size() == 8) begin
      total++;
      if (done_cyc_s !== q_s[7].cyc + 1) begin
        bad++;
        $display("FAIL basic_done_timing got cyc %0d want %0d", done_cyc_s, q_s[7].cyc + 1);
      end
    end
  endtask

  task automatic test_geom_error();
    clear_obs();
    start_frame(3, 4);
    send_frame(4, 8);
    total++;
    if (bus_s.O_geom_error !== 1'b1) begin
      bad++;
      $display("FAIL geom_error_set got %b want 1", bus_s.O_geom_error);
    end
    total++;
    if (q_s.size() !== 0) begin
      bad++;
      $display("FAIL geom_error_no_valid got %0d want 0", q_s.size());
    end
    total++;
    if (u_small.state_r !== S_IDLE) begin
      bad++;
      $display("FAIL geom_error_state got %0d want %0d", u_small.state_r, S_IDLE);
    end
    start_frame(8, 4);
    total++;
    if (bus_s.O_geom_error !== 1'b0) begin
      bad++;
      $display("FAIL geom_error_clear got %b want 0", bus_s.O_geom_error);
    end
    send_frame(4, 8);
    total++;
    if (q_s.size() !== 8) begin
      bad++;
      $display("FAIL geom_resume_count got %0d want 8", q_s.size());
    end
    check_small_grid("geom_resume", 0, 8);
  endtask

  task automatic test_abort();
    clear_obs();
    start_frame(8, 4);
    send_line(0, 8);
    send_line(1, 8);
    send_line(2, 2);
    total++;
    if (q_s.size() !== 5) begin
      bad++;
      $display("FAIL abort_partial_count got %0d want 5", q_s.size());
    end
    start_frame(8, 4);
    repeat (4) @(negedge clk);
    total++;
    if (done_s !== 0) begin
      bad++;
      $display("FAIL abort_no_done got %0d want 0", done_s);
    end
    q_s.delete();
    send_frame(4, 8);
    total++;
    if (q_s.size() !== 8 || done_s !== 1) begin
      bad++;
      $display("FAIL abort_next_frame got count=%0d done=%0d want count=8 done=1", q_s.size(), done_s);
    end
    check_small_grid("abort_next", 0, 8);
  endtask

  task automatic test_overrun();
    int mx;
    int my;
    clear_obs();
    start_frame(8, 4);
    send_frame(5, 10);
    mx = 0;
    my = 0;
    foreach (q_s[k]) begin
      if (q_s[k].x > mx) mx = q_s[k].x;
      if (q_s[k].y > my) my = q_s[k].y;
    end
    total++;
    if (q_s.size() !== 8 || done_s !== 1) begin
      bad++;
      $display("FAIL overrun_count got count=%0d done=%0d want count=8 done=1", q_s.size(), done_s);
    end
    total++;
    if (mx > 3 || my > 1) begin
      bad++;
      $display("FAIL overrun_index_cap got max x=%0d y=%0d want <=3/<=1", mx, my);
    end
    check_small_grid("overrun", 0, 8);
  endtask

  task automatic test_reset_active();
    clear_obs();
    start_frame(8, 4);
    @(negedge clk);
    nrow = 1'b1;
    @(negedge clk);
    nrow = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      de = 1'b1;
      pix = {12'(p), 12'd0};
    end
    @(negedge clk);
    de = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_s.O_sample_valid, bus_s.O_sample_x, bus_s.O_sample_y, bus_s.O_sample_rgb} !== 28'd0) begin
      bad++;
      $display("FAIL reset_active_outputs got v=%b x=%0d rgb=%h want all 0",
               bus_s.O_sample_valid, bus_s.O_sample_x, bus_s.O_sample_rgb);
    end
    total++;
    if (u_small.state_r !== S_IDLE) begin
      bad++;
      $display("FAIL reset_active_state got %0d want %0d", u_small.state_r, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    send_frame(4, 8);
    total++;
    if (q_s.size() !== 0) begin
      bad++;
      $display("FAIL reset_active_idle got %0d samples want 0", q_s.size());
    end
    start_frame(8, 4);
    send_frame(4, 8);
    total++;
    if (q_s.size() !== 8) begin
      bad++;
      $display("FAIL reset_active_resume got %0d want 8", q_s.size());
    end
    check_small_grid("reset_resume", 0, 8);
  endtask

  // Default grid: columns 59+120*x, lines 67+135*y; only selected lines are streamed in full.
  task automatic test_default_geometry();
    logic [23:0] exp;
    clear_obs();
    start_frame(1920, 1080);
    for (int l = 0; l < 1080; l++) begin
      if (l >= 67 && ((l - 67) % 135) == 0) send_line(l, 1920);
      else send_line(l, 1);
    end
    repeat (4) @(negedge clk);
    total++;
    if (q_b.size() !== 128 || done_b !== 1) begin
      bad++;
      $display("FAIL default_count got count=%0d done=%0d want count=128 done=1", q_b.size(), done_b);
    end
    for (int k = 0; k < 128; k++) begin
      if (k < q_b.size()) begin
        exp = {12'(59 + 120 * (k % 16)), 12'(67 + 135 * (k / 16))};
        total++;
        if (q_b[k].x !== k % 16 || q_b[k].y !== k / 16 || q_b[k].rgb !== exp) begin
          bad++;
          $display("FAIL default_sample%0d got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h", k,
                   q_b[k].x, q_b[k].y, q_b[k].rgb, k % 16, k / 16, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_grid();
    test_geom_error();
    test_abort();
    test_overrun();
    test_reset_active();
    test_default_geometry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
